// File: rtl/spmv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spmv_pkg
// Description : Shared widths, FSM state type and output-slot types for the
//               SpMV row dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package spmv_pkg;

    localparam int DEF_PTR_W  = 32;
    localparam int DEF_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  valid;
    } data_slot_t;

    typedef struct packed {
        logic [DEF_PTR_W-1:0] data;
        logic                 valid;
    } times_slot_t;

endpackage
`default_nettype wire

// File: rtl/spmv_row_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : spmv_row_dispatch_if
// Description : Stream and status bundle between CSR/x fetch, the row
//               dispatcher and the dot-product engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface spmv_row_dispatch_if
    import spmv_pkg::*;
#(
    parameter int PTR_W  = DEF_PTR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [PTR_W-1:0]  s_axis_rowptr_tdata;
    logic              s_axis_rowptr_tvalid;
    logic              s_axis_rowptr_tready;
    logic              s_axis_rowptr_tlast;
    logic [DATA_W-1:0] s_axis_val_tdata;
    logic              s_axis_val_tvalid;
    logic              s_axis_val_tready;
    logic [DATA_W-1:0] s_axis_x_tdata;
    logic              s_axis_x_tvalid;
    logic              s_axis_x_tready;
    logic [PTR_W-1:0]  m_axis_times_tdata;
    logic              m_axis_times_tvalid;
    logic              m_axis_times_tready;
    logic [DATA_W-1:0] m_axis_a_tdata;
    logic              m_axis_a_tvalid;
    logic              m_axis_a_tready;
    logic [DATA_W-1:0] m_axis_b_tdata;
    logic              m_axis_b_tvalid;
    logic              m_axis_b_tready;
    logic [PTR_W-1:0]  rows_done;
    logic              done;
    logic              err;

    // Dispatcher view
    modport slave (
        input  s_axis_rowptr_tdata, s_axis_rowptr_tvalid, s_axis_rowptr_tlast,
        output s_axis_rowptr_tready,
        input  s_axis_val_tdata, s_axis_val_tvalid,
        output s_axis_val_tready,
        input  s_axis_x_tdata, s_axis_x_tvalid,
        output s_axis_x_tready,
        output m_axis_times_tdata, m_axis_times_tvalid,
        input  m_axis_times_tready,
        output m_axis_a_tdata, m_axis_a_tvalid,
        input  m_axis_a_tready,
        output m_axis_b_tdata, m_axis_b_tvalid,
        input  m_axis_b_tready,
        output rows_done, done, err
    );

    // Environment view (fetch logic plus dot engine)
    modport master (
        output s_axis_rowptr_tdata, s_axis_rowptr_tvalid, s_axis_rowptr_tlast,
        input  s_axis_rowptr_tready,
        output s_axis_val_tdata, s_axis_val_tvalid,
        input  s_axis_val_tready,
        output s_axis_x_tdata, s_axis_x_tvalid,
        input  s_axis_x_tready,
        input  m_axis_times_tdata, m_axis_times_tvalid,
        output m_axis_times_tready,
        input  m_axis_a_tdata, m_axis_a_tvalid,
        output m_axis_a_tready,
        input  m_axis_b_tdata, m_axis_b_tvalid,
        output m_axis_b_tready,
        input  rows_done, done, err
    );

endinterface
`default_nettype wire

// File: rtl/axis_reg_slice.sv
`default_nettype none
// ============================================================================
// Module      : axis_reg_slice
// Description : Single-entry registered output slot with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_reg_slice #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_free,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             i_tready
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Free when empty or being emptied this cycle, so a reload can overlap
    assign o_free   = ~r_valid | i_tready;
    assign o_tdata  = r_data;
    assign o_tvalid = r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_tready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spmv_row_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : spmv_row_dispatch
// Description : Turns CSR row pointers plus aligned val/x streams into
//               per-row TIMES counts and paired A/B operands.
// Revision    : 1.0 - initial release
// ============================================================================
module spmv_row_dispatch
    import spmv_pkg::*;
#(
    parameter int PTR_W  = DEF_PTR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    spmv_row_dispatch_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_run;
    logic [PTR_W-1:0] r_prev_ptr;
    logic [PTR_W-1:0] r_remaining;
    logic [PTR_W-1:0] r_rows_done;
    logic             r_last;
    logic             r_done;
    logic             r_err;

    logic             w_times_free;
    logic             w_times_valid;
    logic             w_a_free;
    logic             w_a_valid;
    logic             w_b_free;
    logic             w_b_valid;
    logic             w_ptr_ready;
    logic             w_ptr_fire;
    logic             w_ptr_down;
    logic             w_pair_fire;
    logic             w_times_load;
    logic             w_times_fire;
    logic [PTR_W-1:0] w_times;

    // r_run keeps every input ready low until the first cycle after reset
    assign w_ptr_ready  = r_run & ((r_state == ST_IDLE) |
                                   ((r_state == ST_FETCH) & w_times_free));
    assign w_ptr_fire   = w_ptr_ready & bus.s_axis_rowptr_tvalid;
    assign w_ptr_down   = bus.s_axis_rowptr_tdata < r_prev_ptr;
    assign w_times      = w_ptr_down ? '0 : bus.s_axis_rowptr_tdata - r_prev_ptr;
    assign w_times_load = w_ptr_fire & (r_state == ST_FETCH);
    assign w_times_fire = w_times_valid & bus.m_axis_times_tready;
    // A pair moves only as a unit, so val and x can never split
    assign w_pair_fire  = r_run & (r_state == ST_ISSUE) & bus.s_axis_val_tvalid &
                          bus.s_axis_x_tvalid & w_a_free & w_b_free;

    assign bus.s_axis_rowptr_tready = w_ptr_ready;
    assign bus.s_axis_val_tready    = w_pair_fire;
    assign bus.s_axis_x_tready      = w_pair_fire;
    assign bus.rows_done            = r_rows_done;
    assign bus.done                 = r_done;
    assign bus.err                  = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ptr_fire && !bus.s_axis_rowptr_tlast) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (w_ptr_fire) begin
                    if (w_times != '0) begin
                        w_state_nxt = ST_ISSUE;
                    end else if (bus.s_axis_rowptr_tlast) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_ISSUE: begin
                if (w_pair_fire && (r_remaining == PTR_W'(1))) begin
                    w_state_nxt = r_last ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (!w_times_valid && !w_a_valid && !w_b_valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run       <= 1'b0;
            r_prev_ptr  <= '0;
            r_remaining <= '0;
            r_rows_done <= '0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_run  <= 1'b1;
            r_done <= 1'b0;
            if (w_times_fire) begin
                r_rows_done <= r_rows_done + PTR_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_ptr_fire) begin
                        r_prev_ptr  <= bus.s_axis_rowptr_tdata;
                        r_rows_done <= '0;
                        r_done      <= bus.s_axis_rowptr_tlast;
                    end
                end
                ST_FETCH: begin
                    if (w_ptr_fire) begin
                        r_prev_ptr  <= bus.s_axis_rowptr_tdata;
                        r_remaining <= w_times;
                        r_last      <= bus.s_axis_rowptr_tlast;
                        if (w_ptr_down) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_pair_fire) begin
                        r_remaining <= r_remaining - PTR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (w_state_nxt == ST_IDLE) begin
                        r_done     <= 1'b1;
                        r_prev_ptr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    axis_reg_slice #(.WIDTH(PTR_W)) u_times_slot (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_times_load),
        .i_data   (w_times),
        .o_free   (w_times_free),
        .o_tdata  (bus.m_axis_times_tdata),
        .o_tvalid (w_times_valid),
        .i_tready (bus.m_axis_times_tready)
    );

    axis_reg_slice #(.WIDTH(DATA_W)) u_a_slot (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_pair_fire),
        .i_data   (bus.s_axis_val_tdata),
        .o_free   (w_a_free),
        .o_tdata  (bus.m_axis_a_tdata),
        .o_tvalid (w_a_valid),
        .i_tready (bus.m_axis_a_tready)
    );

    axis_reg_slice #(.WIDTH(DATA_W)) u_b_slot (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_pair_fire),
        .i_data   (bus.s_axis_x_tdata),
        .o_free   (w_b_free),
        .o_tdata  (bus.m_axis_b_tdata),
        .o_tvalid (w_b_valid),
        .i_tready (bus.m_axis_b_tready)
    );

    assign bus.m_axis_times_tvalid = w_times_valid;
    assign bus.m_axis_a_tvalid     = w_a_valid;
    assign bus.m_axis_b_tvalid     = w_b_valid;

endmodule
`default_nettype wire

// File: tb/tb_spmv_row_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_spmv_row_dispatch
// Description : Scoreboard bench for spmv_row_dispatch with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spmv_row_dispatch;
    import spmv_pkg::*;

    localparam int PW = DEF_PTR_W;
    localparam int DW = DEF_DATA_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spmv_row_dispatch_if #(.PTR_W(PW), .DATA_W(DW)) bus ();

    spmv_row_dispatch #(.PTR_W(PW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_done  = 0;
    int cnt_t   = 0;
    int cnt_a   = 0;
    int cnt_b   = 0;
    int rmode   = 0;
    int stall_n = 0;
    logic abort = 1'b0;

    logic [63:0] q_times[$];
    logic [63:0] q_a[$];
    logic [63:0] q_b[$];
    logic [31:0] f_ptr[$];
    logic [63:0] f_val[$];
    logic [63:0] f_x[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string why);
        n_total++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Downstream ready patterns
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 1) begin
                bus.m_axis_a_tready = ~bus.m_axis_a_tready;
                bus.m_axis_b_tready = (stall_n >= 5);
                stall_n++;
            end else begin
                bus.m_axis_times_tready = 1'b1;
                bus.m_axis_a_tready     = 1'b1;
                bus.m_axis_b_tready     = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every output handshake
    initial begin
        logic        pa, pb, pt;
        logic [63:0] da, db, dt;
        pa = 1'b0; pb = 1'b0; pt = 1'b0;
        da = '0; db = '0; dt = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pa = 1'b0; pb = 1'b0; pt = 1'b0;
            end else begin
                if (pa) begin
                    chk("a_hold_valid", 64'(bus.m_axis_a_tvalid), 64'd1);
                    chk("a_hold_data", bus.m_axis_a_tdata, da);
                end
                if (pb) begin
                    chk("b_hold_valid", 64'(bus.m_axis_b_tvalid), 64'd1);
                    chk("b_hold_data", bus.m_axis_b_tdata, db);
                end
                if (pt) begin
                    chk("times_hold_valid", 64'(bus.m_axis_times_tvalid), 64'd1);
                    chk("times_hold_data", 64'(bus.m_axis_times_tdata), dt);
                end
                if (bus.m_axis_times_tvalid && bus.m_axis_times_tready) begin
                    cnt_t++;
                    if (q_times.size() == 0) fail_now("times", "unexpected TIMES beat");
                    else chk("times", 64'(bus.m_axis_times_tdata), q_times.pop_front());
                end
                if (bus.m_axis_a_tvalid && bus.m_axis_a_tready) begin
                    cnt_a++;
                    if (q_a.size() == 0) fail_now("a_data", "unexpected A beat");
                    else chk("a_data", bus.m_axis_a_tdata, q_a.pop_front());
                end
                if (bus.m_axis_b_tvalid && bus.m_axis_b_tready) begin
                    cnt_b++;
                    if (q_b.size() == 0) fail_now("b_data", "unexpected B beat");
                    else chk("b_data", bus.m_axis_b_tdata, q_b.pop_front());
                end
                if (bus.done) n_done++;
                pa = bus.m_axis_a_tvalid & ~bus.m_axis_a_tready;
                pb = bus.m_axis_b_tvalid & ~bus.m_axis_b_tready;
                pt = bus.m_axis_times_tvalid & ~bus.m_axis_times_tready;
                da = bus.m_axis_a_tdata;
                db = bus.m_axis_b_tdata;
                dt = 64'(bus.m_axis_times_tdata);
            end
        end
    end

    task automatic feed_ptr();
        int t;
        while (f_ptr.size() > 0 && !abort) begin
            bus.s_axis_rowptr_tdata  = f_ptr[0];
            bus.s_axis_rowptr_tlast  = (f_ptr.size() == 1);
            bus.s_axis_rowptr_tvalid = 1'b1;
            t = 0;
            forever begin
                @(negedge clk);
                if (abort || bus.s_axis_rowptr_tready) break;
                t++;
                if (t > 300) begin
                    fail_now("rowptr_timeout", "pointer never accepted");
                    abort = 1'b1;
                end
            end
            if (abort) break;
            @(posedge clk);
            #1;
            void'(f_ptr.pop_front());
        end
        bus.s_axis_rowptr_tvalid = 1'b0;
        bus.s_axis_rowptr_tlast  = 1'b0;
    endtask

    task automatic feed_val();
        int t;
        while (f_val.size() > 0 && !abort) begin
            bus.s_axis_val_tdata  = f_val[0];
            bus.s_axis_val_tvalid = 1'b1;
            t = 0;
            forever begin
                @(negedge clk);
                if (abort || bus.s_axis_val_tready) break;
                t++;
                if (t > 300) begin
                    fail_now("val_timeout", "value never accepted");
                    abort = 1'b1;
                end
            end
            if (abort) break;
            @(posedge clk);
            #1;
            void'(f_val.pop_front());
        end
        bus.s_axis_val_tvalid = 1'b0;
    endtask

    task automatic feed_x();
        int t;
        while (f_x.size() > 0 && !abort) begin
            bus.s_axis_x_tdata  = f_x[0];
            bus.s_axis_x_tvalid = 1'b1;
            t = 0;
            forever begin
                @(negedge clk);
                if (abort || bus.s_axis_x_tready) break;
                t++;
                if (t > 300) begin
                    fail_now("x_timeout", "x never accepted");
                    abort = 1'b1;
                end
            end
            if (abort) break;
            @(posedge clk);
            #1;
            void'(f_x.pop_front());
        end
        bus.s_axis_x_tvalid = 1'b0;
    endtask

    task automatic run_stream();
        fork
            feed_ptr();
            feed_val();
            feed_x();
        join
    endtask

    task automatic start_test();
        n_done = 0; cnt_t = 0; cnt_a = 0; cnt_b = 0; abort = 1'b0;
    endtask

    task automatic push_pair(input real a, input real b);
        f_val.push_back($realtobits(a));
        f_x.push_back($realtobits(b));
        q_a.push_back($realtobits(a));
        q_b.push_back($realtobits(b));
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (n_done == 0 && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (n_done == 0) fail_now(name, "done never pulsed");
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_done_once"}, 64'(n_done), 64'd1);
        chk({name, "_sb_empty"}, 64'(q_times.size() + q_a.size() + q_b.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.s_axis_rowptr_tdata = '0; bus.s_axis_rowptr_tvalid = 1'b0; bus.s_axis_rowptr_tlast = 1'b0;
        bus.s_axis_val_tdata = '0; bus.s_axis_val_tvalid = 1'b0;
        bus.s_axis_x_tdata = '0; bus.s_axis_x_tvalid = 1'b0;
        bus.m_axis_times_tready = 1'b1; bus.m_axis_a_tready = 1'b1; bus.m_axis_b_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_times_valid", 64'(bus.m_axis_times_tvalid), 64'd0);
        chk("rst_a_valid", 64'(bus.m_axis_a_tvalid), 64'd0);
        chk("rst_b_valid", 64'(bus.m_axis_b_tvalid), 64'd0);
        chk("rst_ptr_ready", 64'(bus.s_axis_rowptr_tready), 64'd0);
        chk("rst_val_ready", 64'(bus.s_axis_val_tready), 64'd0);
        chk("rst_x_ready", 64'(bus.s_axis_x_tready), 64'd0);
        chk("rst_rows_done", 64'(bus.rows_done), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two rows, full throughput
        start_test();
        f_ptr = '{32'd0, 32'd2, 32'd5};
        q_times.push_back(64'd2); q_times.push_back(64'd3);
        push_pair(1.0, 10.0); push_pair(2.0, 20.0); push_pair(3.0, 30.0);
        push_pair(4.0, 40.0); push_pair(5.0, 50.0);
        run_stream();
        wait_done("t1");
        chk("t1_rows_done", 64'(bus.rows_done), 64'd2);
        chk("t1_err", 64'(bus.err), 64'd0);

        // Empty rows around a 3-nnz row
        start_test();
        f_ptr = '{32'd0, 32'd0, 32'd3, 32'd3};
        q_times.push_back(64'd0); q_times.push_back(64'd3); q_times.push_back(64'd0);
        push_pair(6.0, 60.0); push_pair(7.0, 70.0); push_pair(8.0, 80.0);
        run_stream();
        wait_done("t2");
        chk("t2_rows_done", 64'(bus.rows_done), 64'd3);
        chk("t2_pairs", 64'(cnt_a), 64'd3);
        bus.s_axis_val_tdata = $realtobits(99.0); bus.s_axis_val_tvalid = 1'b1;
        bus.s_axis_x_tdata = $realtobits(990.0); bus.s_axis_x_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_extra_val_ready", 64'(bus.s_axis_val_tready), 64'd0);
            chk("t2_extra_x_ready", 64'(bus.s_axis_x_tready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.s_axis_val_tvalid = 1'b0; bus.s_axis_x_tvalid = 1'b0;

        // Downstream stalls: A toggling, B held off
        start_test();
        @(posedge clk);
        #2;
        rmode = 1; stall_n = 0;
        bus.m_axis_a_tready = 1'b0; bus.m_axis_b_tready = 1'b0;
        f_ptr = '{32'd4, 32'd7};
        q_times.push_back(64'd3);
        push_pair(1.0, 10.0); push_pair(2.0, 20.0); push_pair(3.0, 30.0);
        run_stream();
        wait_done("t3");
        @(posedge clk);
        #2;
        rmode = 0;
        chk("t3_a_count", 64'(cnt_a), 64'd3);
        chk("t3_b_count", 64'(cnt_b), 64'd3);
        chk("t3_rows_done", 64'(bus.rows_done), 64'd1);

        // Decreasing pointer
        start_test();
        f_ptr = '{32'd5, 32'd3};
        q_times.push_back(64'd0);
        run_stream();
        wait_done("t4");
        chk("t4_err", 64'(bus.err), 64'd1);
        chk("t4_rows_done", 64'(bus.rows_done), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_err_sticky", 64'(bus.err), 64'd1);

        // Reset in the middle of a 3-nnz row
        start_test();
        f_ptr = '{32'd0, 32'd3};
        q_times.push_back(64'd3);
        push_pair(1.0, 10.0); push_pair(2.0, 20.0); push_pair(3.0, 30.0);
        fork
            run_stream();
        join_none
        for (int t = 0; t < 300 && cnt_a < 2; t++) @(negedge clk);
        if (cnt_a < 2) fail_now("t5_wait_pairs", "second pair never seen");
        @(posedge clk);
        #2;
        rst = 1'b1;
        abort = 1'b1;
        #1;
        chk("t5_times_valid", 64'(bus.m_axis_times_tvalid), 64'd0);
        chk("t5_a_valid", 64'(bus.m_axis_a_tvalid), 64'd0);
        chk("t5_b_valid", 64'(bus.m_axis_b_tvalid), 64'd0);
        chk("t5_val_ready", 64'(bus.s_axis_val_tready), 64'd0);
        chk("t5_err_cleared", 64'(bus.err), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        q_times.delete(); q_a.delete(); q_b.delete();
        f_ptr.delete(); f_val.delete(); f_x.delete();
        bus.s_axis_rowptr_tvalid = 1'b0; bus.s_axis_val_tvalid = 1'b0; bus.s_axis_x_tvalid = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start_test();
        f_ptr = '{32'd0, 32'd1};
        q_times.push_back(64'd1);
        push_pair(9.0, 90.0);
        run_stream();
        wait_done("t5");
        chk("t5_rows_done", 64'(bus.rows_done), 64'd1);
        chk("t5_pairs", 64'(cnt_a), 64'd1);

        // Zero-row matrix
        start_test();
        f_ptr = '{32'd0};
        run_stream();
        wait_done("t6");
        chk("t6_rows_done", 64'(bus.rows_done), 64'd0);
        chk("t6_no_times", 64'(cnt_t), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
